// File: rtl/instr_fetch.sv
// instr_fetch: warp instruction fetch stage with request/return pipeline and run/halt gating
module instr_fetch #(
  parameter int DATA = 32,
  parameter int ADDR = 12,
  parameter logic [4:0] EXIT_OP = 5'b11111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start_TM_IF,
  input  logic [31:0]     PC_in_PC_IF,
  input  logic            GRT_RR_IF,
  input  logic            Flush_IF,
  input  logic            Stall_ID_IF,
  output logic            Req_IF_IM,
  output logic [ADDR-1:0] Addr_IF_IM,
  input  logic [DATA-1:0] Instr_IM_IF,
  output logic            valid_2_IF_PC,
  output logic            valid_3_IF_PC,
  output logic            Valid_IF_ID,
  output logic [DATA-1:0] Instr_IF_ID,
  output logic [31:0]     PC_IF_ID,
  output logic            Halted_IF_TM,
  output logic [15:0]     FetchCnt_IF
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, nextState;
  logic valid2, valid3, hold, capture, exitCap;
  logic [31:0] pc2;
  assign hold = valid3 && Stall_ID_IF;
  assign capture = !Flush_IF && !Start_TM_IF && !hold && valid2;
  assign exitCap = capture && (Instr_IM_IF[DATA-1 -: 5] == EXIT_OP);
  assign Addr_IF_IM = PC_in_PC_IF[ADDR+1:2];
  assign valid_2_IF_PC = valid2;
  assign valid_3_IF_PC = valid3;
  assign Valid_IF_ID = valid3;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  // start from any state enters RUN; an EXIT reaching stage 3 halts
  always_comb
    nextState = Start_TM_IF ? RUN : (state == RUN && exitCap) ? HALT : state;
  // issue a read only when running, granted, not redirected and not holding
  always_comb begin
    Req_IF_IM = (state == RUN) && GRT_RR_IF && !Flush_IF && !Start_TM_IF && !hold;
    Halted_IF_TM = (state == HALT);
  end
  // stage 2: request in flight; the request beside an EXIT capture is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid2 <= 1'b0;
      pc2 <= '0;
    end else begin
      valid2 <= Req_IF_IM && !exitCap;
      if (Req_IF_IM) pc2 <= PC_in_PC_IF;
    end
  // stage 3: redirect empties it, decode stall holds it, otherwise take the return
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid3 <= 1'b0;
      Instr_IF_ID <= '0;
      PC_IF_ID <= '0;
    end else if (Flush_IF || Start_TM_IF) valid3 <= 1'b0;
    else if (!hold) begin
      valid3 <= valid2;
      if (valid2) begin
        Instr_IF_ID <= Instr_IM_IF;
        PC_IF_ID <= pc2;
      end
    end
  // count instructions handed to decode
  always_ff @(posedge clk or posedge rst)
    if (rst) FetchCnt_IF <= '0;
    else if (valid3 && !Stall_ID_IF) FetchCnt_IF <= FetchCnt_IF + 16'd1;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector bench for instr_fetch
module tb_instr_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic startTm = 1'b0, grt = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [31:0] pcIn = '0, instrIm = '0;
  logic req, v2, v3, validId, halted;
  logic [11:0] addr;
  logic [31:0] instrId, pcId;
  logic [15:0] cnt;
  int nTests = 0, nFail = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .Start_TM_IF(startTm), .PC_in_PC_IF(pcIn), .GRT_RR_IF(grt),
    .Flush_IF(flush), .Stall_ID_IF(stall), .Req_IF_IM(req), .Addr_IF_IM(addr),
    .Instr_IM_IF(instrIm), .valid_2_IF_PC(v2), .valid_3_IF_PC(v3), .Valid_IF_ID(validId),
    .Instr_IF_ID(instrId), .PC_IF_ID(pcId), .Halted_IF_TM(halted), .FetchCnt_IF(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, g, fl, sl;
    logic [31:0] pc, im;
    logic req;
    logic [11:0] addr;
    logic v2, v3;
    logic [31:0] po, io;
    logic hl;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic g, logic fl, logic sl, logic [31:0] pc, logic [31:0] im,
                              logic rq, logic [11:0] ad, logic a2, logic a3, logic [31:0] po, logic [31:0] io, logic hl);
    vec_t r;
    r.st = st; r.g = g; r.fl = fl; r.sl = sl; r.pc = pc; r.im = im;
    r.req = rq; r.addr = ad; r.v2 = a2; r.v3 = a3; r.po = po; r.io = io; r.hl = hl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic g, input logic fl, input logic sl, input logic [31:0] pc, input logic [31:0] im);
    startTm = st; grt = g; flush = fl; stall = sl; pcIn = pc; instrIm = im;
  endtask

  initial begin
    vecs.push_back(mk(1,1,0,0,32'h100,32'h0,        0,12'h040,0,0,32'h0,  32'h0,        0));
    vecs.push_back(mk(0,1,0,0,32'h100,32'h0,        1,12'h040,0,0,32'h0,  32'h0,        0));
    vecs.push_back(mk(0,1,0,0,32'h104,32'h10000100, 1,12'h041,1,0,32'h0,  32'h0,        0));
    vecs.push_back(mk(0,1,0,0,32'h108,32'h10000104, 1,12'h042,1,1,32'h100,32'h10000100, 0));
    vecs.push_back(mk(0,1,0,0,32'h10C,32'h10000108, 1,12'h043,1,1,32'h104,32'h10000104, 0));
    vecs.push_back(mk(0,0,0,0,32'h110,32'h1000010C, 0,12'h044,1,1,32'h108,32'h10000108, 0));
    vecs.push_back(mk(0,0,0,0,32'h110,32'h0,        0,12'h044,0,1,32'h10C,32'h1000010C, 0));
    vecs.push_back(mk(0,0,0,0,32'h110,32'h0,        0,12'h044,0,0,32'h10C,32'h1000010C, 0));
    vecs.push_back(mk(0,1,0,0,32'h110,32'h0,        1,12'h044,0,0,32'h10C,32'h1000010C, 0));
    vecs.push_back(mk(0,1,0,0,32'h114,32'h10000110, 1,12'h045,1,0,32'h10C,32'h1000010C, 0));
    vecs.push_back(mk(0,1,0,0,32'h118,32'h10000114, 1,12'h046,1,1,32'h110,32'h10000110, 0));
    vecs.push_back(mk(0,1,0,1,32'h11C,32'h10000118, 0,12'h047,1,1,32'h114,32'h10000114, 0));
    vecs.push_back(mk(0,1,0,1,32'h118,32'h0,        0,12'h046,0,1,32'h114,32'h10000114, 0));
    vecs.push_back(mk(0,1,0,0,32'h118,32'h0,        1,12'h046,0,1,32'h114,32'h10000114, 0));
    vecs.push_back(mk(0,1,0,0,32'h11C,32'h10000118, 1,12'h047,1,0,32'h114,32'h10000114, 0));
    vecs.push_back(mk(0,0,0,0,32'h120,32'h1000011C, 0,12'h048,1,1,32'h118,32'h10000118, 0));
    vecs.push_back(mk(0,0,0,0,32'h120,32'h0,        0,12'h048,0,1,32'h11C,32'h1000011C, 0));
    vecs.push_back(mk(0,1,0,0,32'h120,32'h0,        1,12'h048,0,0,32'h11C,32'h1000011C, 0));
    vecs.push_back(mk(0,1,0,0,32'h124,32'h10000120, 1,12'h049,1,0,32'h11C,32'h1000011C, 0));
    vecs.push_back(mk(0,1,1,1,32'h128,32'h10000124, 0,12'h04A,1,1,32'h120,32'h10000120, 0));
    vecs.push_back(mk(0,0,0,0,32'h200,32'h0,        0,12'h080,0,0,32'h120,32'h10000120, 0));
    vecs.push_back(mk(0,1,0,0,32'h200,32'h0,        1,12'h080,0,0,32'h120,32'h10000120, 0));
    vecs.push_back(mk(0,0,0,0,32'h204,32'h10000200, 0,12'h081,1,0,32'h120,32'h10000120, 0));
    vecs.push_back(mk(0,0,0,0,32'h204,32'h0,        0,12'h081,0,1,32'h200,32'h10000200, 0));
    vecs.push_back(mk(0,1,1,0,32'h204,32'h0,        0,12'h081,0,0,32'h200,32'h10000200, 0));
    vecs.push_back(mk(0,1,0,0,32'h108,32'h0,        1,12'h042,0,0,32'h200,32'h10000200, 0));
    vecs.push_back(mk(0,1,0,0,32'h10C,32'h10000108, 1,12'h043,1,0,32'h200,32'h10000200, 0));
    vecs.push_back(mk(0,1,0,0,32'h110,32'hF8000000, 1,12'h044,1,1,32'h108,32'h10000108, 0));
    vecs.push_back(mk(0,1,0,0,32'h110,32'h0,        0,12'h044,0,1,32'h10C,32'hF8000000, 1));
    vecs.push_back(mk(0,1,0,0,32'h110,32'h0,        0,12'h044,0,0,32'h10C,32'hF8000000, 1));
    vecs.push_back(mk(1,1,0,0,32'h300,32'h0,        0,12'h0C0,0,0,32'h10C,32'hF8000000, 1));
    vecs.push_back(mk(0,1,0,0,32'h300,32'h0,        1,12'h0C0,0,0,32'h10C,32'hF8000000, 0));
    vecs.push_back(mk(0,0,0,0,32'hFFFF4004,32'h10000300, 0,12'h001,1,0,32'h10C,32'hF8000000, 0));
    vecs.push_back(mk(0,0,0,0,32'h304,32'h0,        0,12'h0C1,0,1,32'h300,32'h10000300, 0));

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_v2", {31'b0, v2}, 0);
    chk("rst_v3", {31'b0, v3}, 0);
    chk("rst_pc", pcId, 0);
    chk("rst_instr", instrId, 0);
    chk("rst_cnt", {16'b0, cnt}, 0);
    chk("rst_halt", {31'b0, halted}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].st, vecs[i].g, vecs[i].fl, vecs[i].sl, vecs[i].pc, vecs[i].im);
      #1;
      chk($sformatf("c%0d_req", i), {31'b0, req}, {31'b0, vecs[i].req});
      chk($sformatf("c%0d_addr", i), {20'b0, addr}, {20'b0, vecs[i].addr});
      chk($sformatf("c%0d_v2", i), {31'b0, v2}, {31'b0, vecs[i].v2});
      chk($sformatf("c%0d_v3", i), {31'b0, v3}, {31'b0, vecs[i].v3});
      chk($sformatf("c%0d_validId", i), {31'b0, validId}, {31'b0, vecs[i].v3});
      chk($sformatf("c%0d_pc", i), pcId, vecs[i].po);
      chk($sformatf("c%0d_instr", i), instrId, vecs[i].io);
      chk($sformatf("c%0d_halt", i), {31'b0, halted}, {31'b0, vecs[i].hl});
    end

    @(negedge clk);
    drive(0, 1, 0, 0, 32'h400, 32'h0);
    #1 chk("cnt_after_table", {16'b0, cnt}, 12);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h404, 32'h10000400);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h408, 32'h10000404);
    #1 chk("pre_arst_v3", {31'b0, v3}, 1);
    chk("pre_arst_v2", {31'b0, v2}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, req}, 0);
    chk("arst_v2", {31'b0, v2}, 0);
    chk("arst_v3", {31'b0, v3}, 0);
    chk("arst_pc", pcId, 0);
    chk("arst_instr", instrId, 0);
    chk("arst_cnt", {16'b0, cnt}, 0);
    chk("arst_halt", {31'b0, halted}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k <= 65539; k++) begin
      if (k > 0) @(negedge clk);
      drive(k == 0, 1, 0, 0, 32'h1000 + 32'(k) * 4, 32'h0);
      #1;
      if (k == 10) chk("wrap_cnt_early", {16'b0, cnt}, 7);
      if (k == 65538) chk("wrap_cnt_max", {16'b0, cnt}, 32'hFFFF);
      if (k == 65539) chk("wrap_cnt_zero", {16'b0, cnt}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the warp front end, directly downstream of the PC update unit. Each granted cycle it issues the current PC to the synchronous instruction memory, tracks the request through two pipeline stages (request, return), and presents the returned instruction and its PC to decode. It reports both stage valids back to the PC unit so the PC can rewind on a decode stall. It also gates fetching with a small run/halt state machine driven by thread-manager start and EXIT detection.

## Interface
- DATA, 32, instruction word width
- ADDR, 12, instruction memory word-address width
- EXIT_OP, 5'b11111, opcode value in Instr[31:27] that terminates fetch
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- Start_TM_IF  in  1  thread-manager start pulse, same cycle the PC unit loads StartingPC
- PC_in_PC_IF  in  32  current PC from the PC update unit
- GRT_RR_IF  in  1  round-robin grant; this warp may fetch this cycle
- Flush_IF  in  1  PC redirect this cycle (any branch/SIMT/ALU target update)
- Stall_ID_IF  in  1  decode cannot accept the presented instruction
- Req_IF_IM  out  1  instruction memory read enable
- Addr_IF_IM  out  ADDR  word address, PC_in_PC_IF[ADDR+1:2]
- Instr_IM_IF  in  DATA  read data, valid the cycle after Req_IF_IM
- valid_2_IF_PC  out  1  stage 2 (request in flight) valid
- valid_3_IF_PC  out  1  stage 3 (instruction held) valid
- Valid_IF_ID  out  1  instruction presented to decode; equals valid_3_IF_PC
- Instr_IF_ID  out  DATA  stage 3 instruction
- PC_IF_ID  out  32  stage 3 PC
- Halted_IF_TM  out  1  high while in HALT state
- FetchCnt_IF  out  16  count of instructions accepted by decode

## Operation
- FSM states: IDLE, RUN, HALT. Reset -> IDLE. IDLE/HALT/RUN --Start_TM_IF--> RUN. RUN --EXIT captured into stage 3--> HALT. No other transitions.
- Hold condition H = valid_3 && Stall_ID_IF.
- Request: Req_IF_IM = (state==RUN) && GRT_RR_IF && !Flush_IF && !Start_TM_IF && !H. Addr is combinational from PC_in_PC_IF; upper PC bits above ADDR+1 ignored (address wraps).
- Stage 2 next: valid_2 <= Req_IF_IM; PC_2 <= PC_in_PC_IF when Req_IF_IM.
- Stage 3 next, priority order: (1) Flush_IF or Start_TM_IF: valid_3 <= 0. (2) H: hold valid_3, Instr_3, PC_3; stage 2 content discarded (valid_2 <= 0; the PC unit rewinds by 4 to replay it). (3) else valid_3 <= valid_2; if valid_2, Instr_3 <= Instr_IM_IF, PC_3 <= PC_2.
- Flush_IF or Start_TM_IF also clears valid_2 that edge.
- EXIT: when case (3) captures Instr_IM_IF[31:27]==EXIT_OP, the EXIT instruction is still presented; state -> HALT; any request issued in that same cycle is dropped (valid_2 <= 0 next edge).
- Transfer to decode occurs on a cycle with Valid_IF_ID && !Stall_ID_IF; FetchCnt_IF increments by 1 per transfer, wraps 16'hFFFF -> 0, cleared only by rst.

## Timing
- Reset values: state IDLE, valid_2 0, valid_3 0, Instr_IF_ID 0, PC_IF_ID 0, FetchCnt_IF 0, Halted_IF_TM 0, Req_IF_IM 0 (no grant in IDLE).
- Latency: grant at cycle t -> Req_IF_IM at t -> valid_2 at t+1 (data on Instr_IM_IF) -> Valid_IF_ID at t+2.
- Back-to-back grants give one instruction per cycle at Valid_IF_ID.
- Stall: while H, Req_IF_IM is 0, outputs are stable, valid_2 falls next edge.
- Flush and Stall in same cycle: flush wins; both stages empty next cycle.
- Flush and grant in same cycle: no request; first post-redirect request the following grant cycle.
- rst asserted mid-operation: all state cleared immediately, independent of clk.

## Test plan
- Reset then Start at PC 0x100, grant 4 cycles -> Valid_IF_ID high from cycle t+2, PC_IF_ID 0x100, 0x104, 0x108, 0x10C consecutively; Addr_IF_IM 0x040..0x043.
- Steady fetch, assert Stall_ID_IF 2 cycles with valid_2 and valid_3 high -> Instr/PC_IF_ID held, valid_2 drops, Req_IF_IM 0; after release the replayed PC appears next, no duplicate and no skipped PC.
- Flush_IF with both stages valid -> valid_2, valid_3 both 0 next cycle; target PC 0x200 presented 2 cycles after next grant.
- Memory returns 0xF8000000 (EXIT) at PC 0x10C -> EXIT presented, Halted_IF_TM 1, Req_IF_IM 0 despite grants until Start_TM_IF.
- 65536 transfers -> FetchCnt_IF wraps to 0; stalled cycles do not count.
- Assert rst asynchronously between edges during fetch -> all outputs reset values immediately.
